// File: rtl/vsum_acc.sv
// Reduces each 4-lane signed beat to one sum and accumulates a programmable
// number of beats into a single signed result offered on a valid/ready port.
module vsum_acc #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_0,
    input  logic [WIDTH-1:0]     a_1,
    input  logic [WIDTH-1:0]     a_2,
    input  logic [WIDTH-1:0]     a_3,
    input  logic [LEN_WIDTH-1:0] len,
    output logic [ACC_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [LEN_WIDTH-1:0] cnt;
    logic [ACC_WIDTH-1:0] beat_sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 accept;

    assign in_ready = (state != OUT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        beat_sum = {{(ACC_WIDTH-WIDTH){a_0[WIDTH-1]}}, a_0}
                 + {{(ACC_WIDTH-WIDTH){a_1[WIDTH-1]}}, a_1}
                 + {{(ACC_WIDTH-WIDTH){a_2[WIDTH-1]}}, a_2}
                 + {{(ACC_WIDTH-WIDTH){a_3[WIDTH-1]}}, a_3};
        acc_next = acc + beat_sum;
    end

    // y is loaded with the final sum on the edge that enters OUT, so it is
    // already stable when y_valid rises and simply holds after the result is taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= beat_sum;
                        if (len <= LEN_ONE) begin
                            state   <= OUT;
                            y       <= beat_sum;
                            y_valid <= 1'b1;
                        end else begin
                            cnt   <= len - LEN_ONE;
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt - LEN_ONE;
                        if (cnt == LEN_ONE) begin
                            state   <= OUT;
                            y       <= acc_next;
                            y_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (y_ready) begin
                        state   <= IDLE;
                        y_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
